// File: rtl/shift_merge_pipe.sv
// shift_merge_pipe: two-stage bit-field unit (MASK / EXTR / DEP / DSR) with
// valid/ready handshaking on both sides. Bits are numbered big-endian
// (bit 0 = MSB, bit WIDTH-1 = LSB) for lft/rht field positions.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake
//   op, sext, lft, rht  : operation, EXTR sign-extend, field bounds / DSR shift
//   a, b                : source operand, merge target / low word
//   out_valid/out_ready : result handshake
//   y, err              : result and illegal-field flag
module shift_merge_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             sext,
  input  logic [POS_W-1:0] lft,
  input  logic [POS_W-1:0] rht,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  typedef enum logic [1:0] {
    OP_MASK = 2'b00,
    OP_EXTR = 2'b01,
    OP_DEP  = 2'b10,
    OP_DSR  = 2'b11
  } op_e;

  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [POS_W-1:0] LSB_POS = POS_W'(WIDTH - 1);

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic             s1_sext_q, s1_sext_d;
  logic             s1_err_q, s1_err_d;
  logic             s1_sign_q, s1_sign_d;
  logic [WIDTH-1:0] s1_mask_q, s1_mask_d;
  logic [WIDTH-1:0] s1_low_q, s1_low_d;
  logic [WIDTH-1:0] s1_shf_q, s1_shf_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  // Stage 2 registers (drive the outputs directly)
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             err_q, err_d;

  logic             s1_adv, s2_adv;
  logic             s1_load, s2_load;

  // Pipeline advance: a stage may take new data when empty or draining.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv && !rst;
    s1_load  = in_valid && in_ready;
    s2_load  = s1_valid_q && s2_adv;
  end

  // Stage 1: field mask, pre-shifted operand, sign bit of the field.
  always_comb begin
    logic             bad;
    logic [POS_W-1:0] lo_sh;
    op_e              op_q;

    s1_op_d   = s1_op_q;
    s1_sext_d = s1_sext_q;
    s1_err_d  = s1_err_q;
    s1_sign_d = s1_sign_q;
    s1_mask_d = s1_mask_q;
    s1_low_d  = s1_low_q;
    s1_shf_d  = s1_shf_q;
    s1_b_d    = s1_b_q;

    op_q  = op_e'(op);
    bad   = (lft > rht);
    // Distance from the field's LSB (big-endian rht) to the word LSB.
    lo_sh = LSB_POS - rht;

    if (s1_load) begin
      s1_op_d   = op_q;
      s1_sext_d = sext;
      s1_err_d  = bad && (op_q != OP_DSR);
      s1_b_d    = b;
      // Big-endian position p maps to little-endian bit WIDTH-1-p.
      s1_mask_d = bad ? '0 : ((ONES >> lft) & (ONES << lo_sh));
      s1_low_d  = bad ? '0 : (((ONES >> lft) & (ONES << lo_sh)) >> lo_sh);
      s1_sign_d = |(a & (MSB_BIT >> lft));
      unique case (op_q)
        OP_EXTR: s1_shf_d = a >> lo_sh;
        OP_DEP:  s1_shf_d = a << lo_sh;
        OP_DSR:  s1_shf_d = WIDTH'({a, b} >> rht);
        default: s1_shf_d = '0;
      endcase
    end
  end

  // Stage 2: merge into the final result; an illegal field forces zero.
  always_comb begin
    logic [WIDTH-1:0] res;

    y_d   = y_q;
    err_d = err_q;
    res   = '0;

    unique case (s1_op_q)
      OP_MASK: res = s1_mask_q;
      OP_EXTR: begin
        res = s1_shf_q & s1_low_q;
        if (s1_sext_q && s1_sign_q) res = res | ~s1_low_q;
      end
      OP_DEP:  res = (s1_b_q & ~s1_mask_q) | (s1_shf_q & s1_mask_q);
      OP_DSR:  res = s1_shf_q;
      default: res = '0;
    endcase

    if (s2_load) begin
      y_d   = s1_err_q ? '0 : res;
      err_d = s1_err_q;
    end
  end

  // Valid bits follow the handshake.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_adv) s1_valid_d = s1_load;
    if (s2_adv) s2_valid_d = s1_valid_q;
  end

  // Control and output registers (reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      err_q      <= err_d;
    end
  end

  // Stage 1 payload; only meaningful while s1_valid_q is set.
  always_ff @(posedge clk) begin
    s1_op_q   <= s1_op_d;
    s1_sext_q <= s1_sext_d;
    s1_err_q  <= s1_err_d;
    s1_sign_q <= s1_sign_d;
    s1_mask_q <= s1_mask_d;
    s1_low_q  <= s1_low_d;
    s1_shf_q  <= s1_shf_d;
    s1_b_q    <= s1_b_d;
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_shift_merge_pipe.sv
// Directed bench for shift_merge_pipe (WIDTH=32) with hand-computed results.
module tb_shift_merge_pipe;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic          sext;
  logic [4:0]    lft;
  logic [4:0]    rht;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          err;

  int total;
  int bad;

  shift_merge_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sext      (sext),
    .lft       (lft),
    .rht       (rht),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request with out_ready=1; checks latency, result and err.
  task automatic run_op(input string tag, input logic [1:0] o, input logic s,
                        input logic [4:0] l, input logic [4:0] r,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_y, input logic exp_e);
    int k;
    @(negedge clk);
    op = o; sext = s; lft = l; rht = r; a = av; b = bv; in_valid = 1'b1;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; a = '0; b = '0; op = 2'b00;
    k = 1;
    while (!out_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'd2);
    chk({tag, "_y"}, 64'(y), 64'(exp_y));
    chk({tag, "_err"}, 64'(err), 64'(exp_e));
  endtask

  logic [31:0] got_q [4];
  int          n;
  int          stale;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; sext = 1'b0;
    lft = '0; rht = '0; a = '0; b = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Functional vectors
    run_op("mask_0_10", 2'b00, 1'b0, 5'd0, 5'd10, 32'h0, 32'h0, 32'hFFE00000, 1'b0);
    run_op("mask_full", 2'b00, 1'b0, 5'd0, 5'd31, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
    run_op("mask_lsb",  2'b00, 1'b0, 5'd31, 5'd31, 32'h0, 32'h0, 32'h00000001, 1'b0);
    run_op("extr_u",    2'b01, 1'b0, 5'd8, 5'd15, 32'h12345678, 32'h0, 32'h00000034, 1'b0);
    run_op("extr_s",    2'b01, 1'b1, 5'd0, 5'd3, 32'h80000000, 32'h0, 32'hFFFFFFF8, 1'b0);
    run_op("extr_s_pos", 2'b01, 1'b1, 5'd8, 5'd15, 32'h12345678, 32'h0, 32'h00000034, 1'b0);
    run_op("dep_lo",    2'b10, 1'b0, 5'd24, 5'd31, 32'h000000AB, 32'hFFFFFFFF, 32'hFFFFFFAB, 1'b0);
    run_op("dep_mid",   2'b10, 1'b0, 5'd16, 5'd23, 32'h000000AB, 32'hFFFFFFFF, 32'hFFFFABFF, 1'b0);
    run_op("dsr_4",     2'b11, 1'b0, 5'd0, 5'd4, 32'h00000001, 32'h00000000, 32'h10000000, 1'b0);
    run_op("dsr_0",     2'b11, 1'b0, 5'd0, 5'd0, 32'h12345678, 32'hCAFEBABE, 32'hCAFEBABE, 1'b0);
    run_op("dsr_lft_ign", 2'b11, 1'b0, 5'd20, 5'd4, 32'h00000001, 32'h00000000, 32'h10000000, 1'b0);
    run_op("mask_bad",  2'b00, 1'b0, 5'd20, 5'd10, 32'h0, 32'h0, 32'h00000000, 1'b1);
    run_op("dep_bad",   2'b10, 1'b0, 5'd20, 5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);

    // Stall: three back-to-back requests, consumer blocked
    @(negedge clk);
    out_ready = 1'b0;
    op = 2'b11; sext = 1'b0; lft = '0; rht = '0; a = '0; b = 32'h11111111; in_valid = 1'b1;
    #1;
    chk("stall_rdy1", 64'(in_ready), 64'd1);
    @(negedge clk);
    b = 32'h22222222;
    chk("stall_rdy2", 64'(in_ready), 64'd1);
    @(negedge clk);
    b = 32'h33333333;
    chk("stall_full", 64'(in_ready), 64'd0);
    chk("stall_ov", 64'(out_valid), 64'd1);
    chk("stall_y1", 64'(y), 64'h11111111);
    @(negedge clk);
    b = 32'h44444444;  // must be ignored while in_ready=0
    chk("stall_hold_rdy", 64'(in_ready), 64'd0);
    chk("stall_hold_y", 64'(y), 64'h11111111);
    chk("stall_hold_ov", 64'(out_valid), 64'd1);
    b = 32'h33333333;
    out_ready = 1'b1;
    #1;
    chk("release_rdy", 64'(in_ready), 64'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (out_valid && n < 4) begin
        got_q[n] = y;
        n++;
      end
    end
    chk("drain_count", 64'(n), 64'd3);
    chk("drain_0", 64'(got_q[0]), 64'h11111111);
    chk("drain_1", 64'(got_q[1]), 64'h22222222);
    chk("drain_2", 64'(got_q[2]), 64'h33333333);

    // Reset with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    op = 2'b00; lft = 5'd20; rht = 5'd10; in_valid = 1'b1;
    @(negedge clk);
    lft = 5'd0; rht = 5'd10;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_ov", 64'(out_valid), 64'd1);
    chk("full_err", 64'(err), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    chk("mid_rst_y", 64'(y), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_rdy_after", 64'(in_ready), 64'd1);
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale", 64'(stale), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
